// File: rtl/nios_cpu_jtag_cmd_bridge.sv
// JTAG update-DR to system-clock command bridge: synchronises the udr_toggle
// request, captures sr/ir, pulses one per-channel strobe and handshakes back via ack_toggle.
module nios_cpu_jtag_cmd_bridge #(
  parameter int IR_WIDTH       = 2,
  parameter int DATA_WIDTH     = 38,
  parameter int SYNC_STAGES    = 2,
  parameter int ACTION_BIT     = DATA_WIDTH - 1,
  parameter logic [(2**IR_WIDTH)-1:0] HANDSHAKE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_udr_toggle,
  input  logic [IR_WIDTH-1:0]        i_ir_in,
  input  logic [DATA_WIDTH-1:0]      i_sr,
  input  logic                       i_cmd_done,
  output logic [DATA_WIDTH-1:0]      o_jdo,
  output logic [(2**IR_WIDTH)-1:0]   o_take_action,
  output logic [(2**IR_WIDTH)-1:0]   o_take_no_action,
  output logic                       o_busy,
  output logic                       o_ack_toggle,
  output logic [7:0]                 o_overrun_cnt,
  output logic                       o_timeout_flag
);

  localparam int NCMD = 2**IR_WIDTH;

  typedef enum logic [2:0] {
    S_WARMUP,
    S_IDLE,
    S_CAPTURE,
    S_ACT,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_prev;
  logic [2:0]              r_warm;
  logic [15:0]             r_tmo_cnt;
  logic [IR_WIDTH-1:0]     r_ir_q;
  logic [DATA_WIDTH-1:0]   r_jdo;
  logic [NCMD-1:0]         r_take_action;
  logic [NCMD-1:0]         r_take_no_action;
  logic                    r_busy;
  logic                    r_ack_toggle;
  logic [7:0]              r_overrun_cnt;
  logic                    r_timeout_flag;

  logic                    w_edge;
  logic [NCMD-1:0]         w_onehot;

  // The previous copy tracks the synchroniser every cycle, so any level change is a single-cycle edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_udr_toggle};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge   = r_sync[SYNC_STAGES-1] ^ r_prev;
  assign w_onehot = {{(NCMD-1){1'b0}}, 1'b1} << r_ir_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_WARMUP;
      r_warm           <= '0;
      r_tmo_cnt        <= '0;
      r_ir_q           <= '0;
      r_jdo            <= '0;
      r_take_action    <= '0;
      r_take_no_action <= '0;
      r_busy           <= 1'b1;
      r_ack_toggle     <= 1'b0;
      r_overrun_cnt    <= '0;
      r_timeout_flag   <= 1'b0;
    end else begin
      r_take_action    <= '0;
      r_take_no_action <= '0;
      // Edges outside IDLE are dropped; WARMUP edges are start-up artefacts and not counted.
      if (w_edge && (r_state != S_WARMUP) && (r_state != S_IDLE) && (r_overrun_cnt != 8'hFF))
        r_overrun_cnt <= r_overrun_cnt + 8'd1;
      case (r_state)
        S_WARMUP: begin
          if (r_warm == 3'(SYNC_STAGES)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_warm <= r_warm + 3'd1;
          end
        end
        S_IDLE: begin
          if (w_edge) begin
            r_jdo   <= i_sr;
            r_ir_q  <= i_ir_in;
            r_state <= S_CAPTURE;
            r_busy  <= 1'b1;
          end
        end
        S_CAPTURE: begin
          r_state <= S_ACT;
          if (r_jdo[ACTION_BIT])
            r_take_action <= w_onehot;
          else
            r_take_no_action <= w_onehot;
        end
        S_ACT: begin
          r_tmo_cnt <= '0;
          if (HANDSHAKE_MASK[r_ir_q])
            r_state <= S_WAIT;
          else
            r_state <= S_ACK;
        end
        S_WAIT: begin
          if (i_cmd_done) begin
            r_state   <= S_ACK;
            r_tmo_cnt <= '0;
          end else if (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            r_state        <= S_ACK;
            r_tmo_cnt      <= '0;
            r_timeout_flag <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        S_ACK: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_ack_toggle <= ~r_ack_toggle;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_jdo            = r_jdo;
  assign o_take_action    = r_take_action;
  assign o_take_no_action = r_take_no_action;
  assign o_busy           = r_busy;
  assign o_ack_toggle     = r_ack_toggle;
  assign o_overrun_cnt    = r_overrun_cnt;
  assign o_timeout_flag   = r_timeout_flag;

endmodule

// File: tb/tb_nios_cpu_jtag_cmd_bridge.sv
// Directed bench for nios_cpu_jtag_cmd_bridge: latency, handshake, timeout,
// overrun saturation and reset behaviour with hand-computed expectations.
module tb_nios_cpu_jtag_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        udrToggle;
  logic [1:0]  irIn;
  logic [37:0] sr;
  logic        cmdDone;
  logic [37:0] jdo;
  logic [3:0]  takeAction;
  logic [3:0]  takeNoAction;
  logic        busy;
  logic        ackToggle;
  logic [7:0]  overrunCnt;
  logic        timeoutFlag;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  nios_cpu_jtag_cmd_bridge #(
    .IR_WIDTH       (2),
    .DATA_WIDTH     (38),
    .SYNC_STAGES    (2),
    .HANDSHAKE_MASK (4'b0010),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_udr_toggle     (udrToggle),
    .i_ir_in          (irIn),
    .i_sr             (sr),
    .i_cmd_done       (cmdDone),
    .o_jdo            (jdo),
    .o_take_action    (takeAction),
    .o_take_no_action (takeNoAction),
    .o_busy           (busy),
    .o_ack_toggle     (ackToggle),
    .o_overrun_cnt    (overrunCnt),
    .o_timeout_flag   (timeoutFlag)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic tog, input logic [1:0] ir, input logic [37:0] data);
    udrToggle = tog;
    irIn      = ir;
    sr        = data;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_jdo"},   64'(jdo), 64'h0);
    checkOutput({tag, "_take"},  64'({takeAction, takeNoAction}), 64'h0);
    checkOutput({tag, "_busy"},  64'(busy), 64'h1);
    checkOutput({tag, "_ack"},   64'(ackToggle), 64'h0);
    checkOutput({tag, "_ovr"},   64'(overrunCnt), 64'h0);
    checkOutput({tag, "_tmo"},   64'(timeoutFlag), 64'h0);
  endtask

  initial begin
    reset   = 1'b1;
    cmdDone = 1'b0;
    applyStimulus(1'b0, 2'd0, 38'h0);
    tick(3);
    checkResetState("rst");

    reset = 1'b0;
    tick(2);
    checkOutput("warm_busy", 64'(busy), 64'h1);
    tick(1);
    checkOutput("idle_busy", 64'(busy), 64'h0);

    // Action command on a non-handshake channel
    applyStimulus(1'b1, 2'd2, 38'h20_0000_00AB);
    tick(2);
    checkOutput("a_jdo_e2", 64'(jdo), 64'h0);
    tick(1);
    checkOutput("a_jdo_e3", 64'(jdo), 64'h20_0000_00AB);
    checkOutput("a_take_e3", 64'({takeAction, takeNoAction}), 64'h00);
    checkOutput("a_busy_e3", 64'(busy), 64'h1);
    tick(1);
    checkOutput("a_take_e4", 64'({takeAction, takeNoAction}), 64'h40);
    tick(1);
    checkOutput("a_take_e5", 64'({takeAction, takeNoAction}), 64'h00);
    checkOutput("a_ack_e5", 64'(ackToggle), 64'h0);
    tick(1);
    checkOutput("a_ack_e6", 64'(ackToggle), 64'h1);
    checkOutput("a_busy_e6", 64'(busy), 64'h0);
    checkOutput("a_ovr", 64'(overrunCnt), 64'h0);

    // No-action command on handshake channel, completed by cmd_done
    applyStimulus(1'b0, 2'd1, 38'h0_1234_5678);
    tick(3);
    checkOutput("b_jdo", 64'(jdo), 64'h0_1234_5678);
    tick(1);
    checkOutput("b_take_e4", 64'({takeAction, takeNoAction}), 64'h02);
    tick(1);
    checkOutput("b_take_e5", 64'({takeAction, takeNoAction}), 64'h00);
    tick(5);
    checkOutput("b_wait_busy", 64'(busy), 64'h1);
    checkOutput("b_wait_ack", 64'(ackToggle), 64'h1);
    cmdDone = 1'b1;
    tick(1);
    cmdDone = 1'b0;
    checkOutput("b_ackst_busy", 64'(busy), 64'h1);
    checkOutput("b_ackst_ack", 64'(ackToggle), 64'h1);
    tick(1);
    checkOutput("b_ack", 64'(ackToggle), 64'h0);
    checkOutput("b_busy", 64'(busy), 64'h0);
    checkOutput("b_tmo", 64'(timeoutFlag), 64'h0);

    // Handshake channel with no cmd_done: WAIT must time out after 16 cycles
    applyStimulus(1'b1, 2'd1, 38'h20_0000_0001);
    tick(4);
    checkOutput("c_take_e4", 64'({takeAction, takeNoAction}), 64'h20);
    tick(16);
    checkOutput("c_tmo_e20", 64'(timeoutFlag), 64'h0);
    checkOutput("c_busy_e20", 64'(busy), 64'h1);
    tick(1);
    checkOutput("c_tmo_e21", 64'(timeoutFlag), 64'h1);
    checkOutput("c_ack_e21", 64'(ackToggle), 64'h0);
    tick(1);
    checkOutput("c_ack_e22", 64'(ackToggle), 64'h1);
    checkOutput("c_busy_e22", 64'(busy), 64'h0);

    // Second toggle arrives while the first command is still in flight
    applyStimulus(1'b0, 2'd2, 38'h20_0000_0011);
    tick(3);
    udrToggle = 1'b1;
    tick(1);
    checkOutput("d_take_e4", 64'({takeAction, takeNoAction}), 64'h40);
    tick(2);
    checkOutput("d_ovr", 64'(overrunCnt), 64'h1);
    checkOutput("d_ack", 64'(ackToggle), 64'h0);
    tick(4);
    checkOutput("d_busy_after", 64'(busy), 64'h0);
    checkOutput("d_ack_after", 64'(ackToggle), 64'h0);
    checkOutput("d_tmo_sticky", 64'(timeoutFlag), 64'h1);

    // Toggle every cycle: three of every four edges are dropped
    for (int i = 0; i < 600; i++) begin
      udrToggle = ~udrToggle;
      tick(1);
    end
    tick(12);
    checkOutput("sat_ovr", 64'(overrunCnt), 64'hFF);
    checkOutput("sat_busy", 64'(busy), 64'h0);
    checkOutput("sat_tmo", 64'(timeoutFlag), 64'h1);

    // udr_toggle held high through reset must not create a request
    udrToggle = 1'b1;
    reset     = 1'b1;
    tick(2);
    checkResetState("rst2");
    reset = 1'b0;
    tick(3);
    checkOutput("e_warm_busy", 64'(busy), 64'h0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checkOutput("e_quiet_take", 64'({takeAction, takeNoAction}), 64'h00);
      checkOutput("e_quiet_busy", 64'(busy), 64'h0);
    end
    checkOutput("e_ack", 64'(ackToggle), 64'h0);
    checkOutput("e_ovr", 64'(overrunCnt), 64'h0);

    // Reset asserted while the bridge sits in WAIT
    applyStimulus(1'b0, 2'd1, 38'h0_0000_0055);
    tick(5);
    checkOutput("f_wait_busy", 64'(busy), 64'h1);
    tick(3);
    reset = 1'b1;
    tick(1);
    checkResetState("rst3");
    reset = 1'b0;
    tick(3);
    checkOutput("f_idle_busy", 64'(busy), 64'h0);
    tick(8);
    checkOutput("f_ack", 64'(ackToggle), 64'h0);
    checkOutput("f_take", 64'({takeAction, takeNoAction}), 64'h00);
    checkOutput("f_busy", 64'(busy), 64'h0);
    checkOutput("f_tmo", 64'(timeoutFlag), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
